// File: rtl/soc_event_pkg.sv
// Shared defaults and types for the SoC event queue.
package soc_event_pkg;

    localparam int unsigned NUM_EVENTS_DEFAULT = 128;
    localparam int unsigned FIFO_DEPTH_DEFAULT = 8;
    localparam int unsigned EVT_ID_WIDTH       = $clog2(NUM_EVENTS_DEFAULT);

    typedef logic [EVT_ID_WIDTH-1:0] event_id_t;

    // Lost-event counter saturates here instead of wrapping.
    localparam logic [15:0] DROP_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/fifo_v3.sv
// Synchronous FIFO with flush; optional fall-through when empty.
// usage reads 0 when full; combine with full_o for the true occupancy.
module fifo_v3 #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    localparam int unsigned ADDR_DEPTH  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_DEPTH-1:0] usage_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  pop_i
);

    logic [ADDR_DEPTH-1:0] rd_ptr, wr_ptr;
    logic [ADDR_DEPTH:0]   cnt;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  bypass, do_push, do_pop;

    // Status, read data and the push/pop qualifiers.
    always_comb begin
        full_o  = (cnt == (ADDR_DEPTH+1)'(DEPTH));
        empty_o = (cnt == '0) && !(FALL_THROUGH && push_i);
        usage_o = cnt[ADDR_DEPTH-1:0];
        bypass  = FALL_THROUGH && (cnt == '0) && push_i && pop_i;
        data_o  = (FALL_THROUGH && (cnt == '0)) ? data_i : mem[rd_ptr];
        do_push = push_i && !full_o && !bypass;
        do_pop  = pop_i && (cnt != '0) && !bypass;
    end

    // Pointer and occupancy bookkeeping; flush empties the queue.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push)
                wr_ptr <= (wr_ptr == ADDR_DEPTH'(DEPTH-1)) ? '0 : wr_ptr + ADDR_DEPTH'(1);
            if (do_pop)
                rd_ptr <= (rd_ptr == ADDR_DEPTH'(DEPTH-1)) ? '0 : rd_ptr + ADDR_DEPTH'(1);
            cnt <= cnt + (ADDR_DEPTH+1)'(do_push) - (ADDR_DEPTH+1)'(do_pop);
        end
    end

    // Storage is not reset; empty slots are never presented downstream.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem[wr_ptr] <= data_i;
    end

endmodule

// File: rtl/soc_event_rr_pick.sv
// Round-robin find-first: lowest pending index at or above rr_ptr,
// wrapping to the lowest pending index overall.
module soc_event_rr_pick #(
    parameter int unsigned NUM_EVENTS = 128,
    localparam int unsigned ID_WIDTH  = $clog2(NUM_EVENTS)
) (
    input  logic [NUM_EVENTS-1:0] pending,
    input  logic [ID_WIDTH-1:0]   rr_ptr,
    output logic                  gnt_valid,
    output logic [ID_WIDTH-1:0]   gnt_id
);

    logic [ID_WIDTH-1:0] id_any, id_hi;
    logic                found_hi;

    // Scan downward so the last hit written is the lowest index.
    always_comb begin
        id_any   = '0;
        id_hi    = '0;
        found_hi = 1'b0;
        for (int i = int'(NUM_EVENTS) - 1; i >= 0; i--) begin
            if (pending[i]) begin
                id_any = ID_WIDTH'(i);
                if (ID_WIDTH'(i) >= rr_ptr) begin
                    id_hi    = ID_WIDTH'(i);
                    found_hi = 1'b1;
                end
            end
        end
        gnt_valid = |pending;
        gnt_id    = found_hi ? id_hi : id_any;
    end

endmodule

// File: rtl/soc_event_queue.sv
// Latches event pulses into pending bits, drains them round-robin into an
// ID FIFO popped by the core, and counts events that re-fire while pending.
module soc_event_queue
    import soc_event_pkg::*;
#(
    parameter int unsigned NUM_EVENTS = NUM_EVENTS_DEFAULT,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
    localparam int unsigned ID_WIDTH  = $clog2(NUM_EVENTS),
    localparam int unsigned CNT_WIDTH = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic [NUM_EVENTS-1:0] events_i,
    output logic                  evt_valid_o,
    output logic [ID_WIDTH-1:0]   evt_id_o,
    input  logic                  evt_ready_i,
    output logic                  irq_o,
    output logic [CNT_WIDTH-1:0]  fifo_count_o,
    output logic [15:0]           drop_cnt_o,
    output logic                  overflow_o
);

    localparam int unsigned SUM_W = ((ID_WIDTH + 1 > 16) ? ID_WIDTH + 1 : 16) + 1;

    logic [NUM_EVENTS-1:0] pending, gnt_mask, lost;
    logic [ID_WIDTH-1:0]   rr_ptr, gnt_id, fifo_data;
    logic                  gnt_any, grant;
    logic                  fifo_full, fifo_empty;
    logic [CNT_WIDTH-2:0]  fifo_usage;
    logic [ID_WIDTH:0]     lost_cnt;
    logic [SUM_W-1:0]      drop_sum;
    logic [15:0]           drop_cnt, drop_next;
    logic                  overflow;

    soc_event_rr_pick #(.NUM_EVENTS(NUM_EVENTS)) u_pick (
        .pending   (pending),
        .rr_ptr    (rr_ptr),
        .gnt_valid (gnt_any),
        .gnt_id    (gnt_id)
    );

    // Grant only against the registered occupancy, so a same-cycle pop
    // never frees a slot for this cycle's push.
    always_comb begin
        grant    = gnt_any && !fifo_full;
        gnt_mask = grant ? (NUM_EVENTS'(1) << gnt_id) : '0;
        lost     = events_i & pending & ~gnt_mask;
        lost_cnt = '0;
        for (int i = 0; i < int'(NUM_EVENTS); i++)
            lost_cnt = lost_cnt + (ID_WIDTH+1)'(lost[i]);
        drop_sum  = SUM_W'(drop_cnt) + SUM_W'(lost_cnt);
        drop_next = (drop_sum > SUM_W'(DROP_CNT_MAX)) ? DROP_CNT_MAX : drop_sum[15:0];
    end

    // Pending bits, round-robin pointer and loss tracking; clear wins.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending  <= '0;
            rr_ptr   <= '0;
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else if (clear_i) begin
            pending  <= '0;
            rr_ptr   <= '0;
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            pending  <= (pending & ~gnt_mask) | events_i;
            if (grant) rr_ptr <= gnt_id + ID_WIDTH'(1);
            drop_cnt <= drop_next;
            if (|lost) overflow <= 1'b1;
        end
    end

    fifo_v3 #(
        .FALL_THROUGH (1'b0),
        .DATA_WIDTH   (ID_WIDTH),
        .DEPTH        (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (clear_i),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .usage_o (fifo_usage),
        .data_i  (gnt_id),
        .push_i  (grant && !clear_i),
        .data_o  (fifo_data),
        .pop_i   (evt_valid_o && evt_ready_i && !clear_i)
    );

    // Output view of the FIFO head and status.
    always_comb begin
        evt_valid_o  = !fifo_empty;
        evt_id_o     = fifo_empty ? '0 : fifo_data;
        irq_o        = evt_valid_o;
        fifo_count_o = fifo_full ? CNT_WIDTH'(FIFO_DEPTH) : {1'b0, fifo_usage};
        drop_cnt_o   = drop_cnt;
        overflow_o   = overflow;
    end

endmodule

// File: tb/tb_soc_event_queue.sv
// Bench for soc_event_queue: directed table, hand-written corner sequences
// and random traffic, all checked against a queue-based reference model.
module tb_soc_event_queue;
    import soc_event_pkg::*;

    localparam int NE = 128;
    localparam int FD = 8;

    logic          clk_i = 1'b0;
    logic          rst_ni, clear_i, evt_ready_i;
    logic [NE-1:0] events_i;
    logic          evt_valid_o, irq_o, overflow_o;
    event_id_t     evt_id_o;
    logic [3:0]    fifo_count_o;
    logic [15:0]   drop_cnt_o;

    soc_event_queue dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clear_i      (clear_i),
        .events_i     (events_i),
        .evt_valid_o  (evt_valid_o),
        .evt_id_o     (evt_id_o),
        .evt_ready_i  (evt_ready_i),
        .irq_o        (irq_o),
        .fifo_count_o (fifo_count_o),
        .drop_cnt_o   (drop_cnt_o),
        .overflow_o   (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state.
    bit m_pend[NE];
    int m_rr;
    int m_q[$];
    int m_drop;
    bit m_ovf;
    int delivered[$];

    typedef struct {
        logic [NE-1:0] ev;
        logic          rdy;
        logic          clr;
        logic          exp_v;
        int            exp_id;
        int            exp_cnt;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_rr = 0;
        m_q.delete();
        m_drop = 0;
        m_ovf = 1'b0;
    endfunction

    function automatic void model_step(input logic [NE-1:0] ev, input logic rdy, input logic clr);
        int g;
        int lost;
        if (clr) begin
            model_reset();
            return;
        end
        g = -1;
        if (m_q.size() < FD)
            for (int k = 0; k < NE; k++)
                if (g < 0 && m_pend[(m_rr + k) % NE]) g = (m_rr + k) % NE;
        lost = 0;
        for (int i = 0; i < NE; i++)
            if (ev[i] && m_pend[i] && i != g) lost++;
        for (int i = 0; i < NE; i++)
            if (i == g) m_pend[i] = ev[i];
            else if (ev[i]) m_pend[i] = 1'b1;
        if (rdy && m_q.size() != 0) void'(m_q.pop_front());
        if (g >= 0) begin
            m_q.push_back(g);
            m_rr = (g + 1) % NE;
        end
        m_drop = m_drop + lost;
        if (m_drop > 65535) m_drop = 65535;
        if (lost > 0) m_ovf = 1'b1;
    endfunction

    task automatic model_check();
        chk("valid", int'(evt_valid_o), (m_q.size() != 0) ? 1 : 0);
        chk("id", int'(evt_id_o), (m_q.size() != 0) ? m_q[0] : 0);
        chk("irq", int'(irq_o), (m_q.size() != 0) ? 1 : 0);
        chk("count", int'(fifo_count_o), m_q.size());
        chk("drop", int'(drop_cnt_o), m_drop);
        chk("overflow", int'(overflow_o), int'(m_ovf));
    endtask

    // One clock: drive at posedge+1, sample and check at negedge.
    task automatic cycle(input logic [NE-1:0] ev, input logic rdy, input logic clr,
                         output logic v, output int id, output int cnt);
        events_i    = ev;
        evt_ready_i = rdy;
        clear_i     = clr;
        @(negedge clk_i);
        v   = evt_valid_o;
        id  = int'(evt_id_o);
        cnt = int'(fifo_count_o);
        model_check();
        if (evt_valid_o && evt_ready_i && !clear_i) delivered.push_back(int'(evt_id_o));
        model_step(ev, rdy, clr);
        @(posedge clk_i);
        #1;
    endtask

    task automatic run(input logic [NE-1:0] ev, input logic rdy, input logic clr);
        logic v;
        int   id, cnt;
        cycle(ev, rdy, clr, v, id, cnt);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) run('0, rdy, 1'b0);
    endtask

    function automatic int count_id(input int id);
        int n = 0;
        foreach (delivered[i]) if (delivered[i] == id) n++;
        return n;
    endfunction

    function automatic logic [NE-1:0] bit_of(input int i);
        logic [NE-1:0] m = '0;
        m[i] = 1'b1;
        return m;
    endfunction

    function automatic void add_row(input logic [NE-1:0] ev, input logic rdy, input logic clr,
                                    input logic v, input int id, input int cnt);
        vec_t r;
        r.ev = ev; r.rdy = rdy; r.clr = clr;
        r.exp_v = v; r.exp_id = id; r.exp_cnt = cnt;
        tbl.push_back(r);
    endfunction

    initial begin
        logic [NE-1:0] m3, all1;
        logic          v;
        int            id, cnt;

        rst_ni = 1'b0; clear_i = 1'b0; evt_ready_i = 1'b0; events_i = '0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_valid", int'(evt_valid_o), 0);
        chk("rst_id", int'(evt_id_o), 0);
        chk("rst_count", int'(fifo_count_o), 0);
        chk("rst_drop", int'(drop_cnt_o), 0);
        chk("rst_overflow", int'(overflow_o), 0);
        rst_ni = 1'b1;

        // Three simultaneous events drain in index order from rr_ptr=0,
        // then a lone pulse appears two cycles later for one cycle.
        m3 = bit_of(5) | bit_of(90) | bit_of(127);
        add_row(m3, 0, 0, 0, 0, 0);
        add_row('0, 0, 0, 0, 0, 0);
        add_row('0, 0, 0, 1, 5, 1);
        add_row('0, 0, 0, 1, 5, 2);
        add_row('0, 1, 0, 1, 5, 3);
        add_row('0, 1, 0, 1, 90, 2);
        add_row('0, 1, 0, 1, 127, 1);
        add_row('0, 1, 0, 0, 0, 0);
        add_row(bit_of(37), 1, 0, 0, 0, 0);
        add_row('0, 1, 0, 0, 0, 0);
        add_row('0, 1, 0, 1, 37, 1);
        add_row('0, 1, 0, 0, 0, 0);
        add_row('0, 1, 0, 0, 0, 0);
        foreach (tbl[r]) begin
            cycle(tbl[r].ev, tbl[r].rdy, tbl[r].clr, v, id, cnt);
            chk($sformatf("tbl%0d_valid", r), int'(v), int'(tbl[r].exp_v));
            chk($sformatf("tbl%0d_id", r), id, tbl[r].exp_id);
            chk($sformatf("tbl%0d_count", r), cnt, tbl[r].exp_cnt);
        end

        // Move rr_ptr to 91, then the same triple pops as 127,5,90.
        run(bit_of(90), 1, 0);
        idle(4, 1);
        delivered.delete();
        run(m3, 0, 0);
        idle(4, 0);
        idle(6, 1);
        chk("rr91_n", delivered.size(), 3);
        if (delivered.size() == 3) begin
            chk("rr91_first", delivered[0], 127);
            chk("rr91_second", delivered[1], 5);
            chk("rr91_third", delivered[2], 90);
        end

        // Ten events against an 8-deep FIFO with the consumer stalled.
        run('0, 0, 1);
        run({118'd0, 10'h3FF} << 10, 0, 0);
        idle(14, 0);
        chk("full_count", int'(fifo_count_o), 8);
        chk("full_drop", int'(drop_cnt_o), 0);
        delivered.delete();
        idle(20, 1);
        chk("full_delivered", delivered.size(), 10);
        for (int i = 10; i < 20; i++) chk($sformatf("full_id%0d", i), count_id(i), 1);

        // Event 3 fires twice while the FIFO is full: one loss, one delivery.
        run('0, 0, 1);
        run({120'd0, 8'hFF} << 20, 0, 0);
        idle(12, 0);
        run(bit_of(3), 0, 0);
        idle(1, 0);
        run(bit_of(3), 0, 0);
        idle(1, 0);
        chk("dbl_drop", int'(drop_cnt_o), 1);
        chk("dbl_overflow", int'(overflow_o), 1);
        delivered.delete();
        idle(20, 1);
        chk("dbl_id3", count_id(3), 1);

        // Re-fire exactly in the grant cycle: delivered twice, nothing lost.
        run('0, 1, 1);
        delivered.delete();
        run(bit_of(3), 1, 0);
        run(bit_of(3), 1, 0);
        idle(6, 1);
        chk("regrant_id3", count_id(3), 2);
        chk("regrant_drop", int'(drop_cnt_o), 0);

        // Saturate the loss counter, then clear with an event in the clear cycle.
        all1 = '1;
        for (int i = 0; i < 700; i++) run(all1, 0, 0);
        chk("sat_drop", int'(drop_cnt_o), 65535);
        chk("sat_overflow", int'(overflow_o), 1);
        run(bit_of(50), 0, 1);
        chk("clr_valid", int'(evt_valid_o), 0);
        chk("clr_count", int'(fifo_count_o), 0);
        chk("clr_drop", int'(drop_cnt_o), 0);
        chk("clr_overflow", int'(overflow_o), 0);
        chk("clr_id", int'(evt_id_o), 0);
        delivered.delete();
        idle(6, 1);
        chk("clr_no_delivery", delivered.size(), 0);

        // Random traffic: sparse pulses, bursty ready, rare clears.
        for (int c = 0; c < 3000; c++) begin
            logic [NE-1:0] ev = '0;
            int n = $urandom_range(0, 3);
            for (int k = 0; k < n; k++) ev[$urandom_range(0, NE - 1)] = 1'b1;
            if ($urandom_range(0, 15) == 0) ev = ev | bit_of($urandom_range(0, 7));
            run(ev, ((c / 50) % 3 == 2) ? 1'b0 : ($urandom_range(0, 3) != 0),
                $urandom_range(0, 399) == 0);
        end

        // Asynchronous reset in the middle of activity.
        for (int i = 0; i < 20; i++) run(all1, 0, 0);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_valid", int'(evt_valid_o), 0);
        chk("arst_count", int'(fifo_count_o), 0);
        chk("arst_drop", int'(drop_cnt_o), 0);
        chk("arst_overflow", int'(overflow_o), 0);
        model_reset();
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        for (int c = 0; c < 200; c++) begin
            logic [NE-1:0] ev = '0;
            ev[$urandom_range(0, NE - 1)] = ($urandom_range(0, 1) == 1);
            run(ev, $urandom_range(0, 1) == 1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
